// File: rtl/fetch_pkg.sv
// Shared types for the instruction fetch unit: FSM states, instruction
// width, PC step and the FIFO entry pairing an instruction with its PC.
package fetch_pkg;

    localparam int INSTR_W = 32;
    localparam int PC_STEP = 4;
    localparam int PC_W    = 64;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        DROP = 2'd2
    } fetch_state_t;

    typedef struct packed {
        logic [PC_W-1:0]    pc;
        logic [INSTR_W-1:0] instr;
    } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// Small synchronous FIFO of fetch entries; flush beats push and pop.
// The head is read straight out of the register array.
module fetch_fifo
    import fetch_pkg::*;
#(
    parameter int DEPTH = 2,
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    localparam int CNT_W = $clog2(DEPTH) + 1
)(
    input  logic         clk,
    input  logic         rst_n,
    input  logic         push,
    input  logic         pop,
    input  logic         flush,
    input  fetch_entry_t din,
    output logic [CNT_W-1:0] count,
    output logic         full,
    output logic         empty,
    output fetch_entry_t head
);

    fetch_entry_t     r_mem [DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [CNT_W-1:0] r_count;
    logic             w_do_push;
    logic             w_do_pop;

    assign full      = (r_count == CNT_W'(DEPTH));
    assign empty     = (r_count == '0);
    assign count     = r_count;
    assign head      = r_mem[r_rd_ptr];
    assign w_do_push = push && (!full || pop);
    assign w_do_pop  = pop && !empty;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
        end else if (flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) begin
                r_mem[r_wr_ptr] <= din;
                r_wr_ptr        <= r_wr_ptr + PTR_W'(1);
            end
            if (w_do_pop) r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            r_count <= r_count + CNT_W'(w_do_push) - CNT_W'(w_do_pop);
        end
    end

endmodule

// File: rtl/instr_fetch_unit.sv
// Instruction fetch: owns the PC, keeps one imem request in flight and
// buffers responses in a prefetch FIFO feeding the datapath.
module instr_fetch_unit
    import fetch_pkg::*;
#(
    parameter int              XLEN      = 64,
    parameter logic [XLEN-1:0] RESET_PC  = '0,
    parameter int              BUF_DEPTH = 2
)(
    input  logic               clk,
    input  logic               rst_n,
    output logic               imem_req,
    output logic [XLEN-1:0]    imem_addr,
    input  logic               imem_rvalid,
    input  logic [INSTR_W-1:0] imem_rdata,
    output logic               instr_valid,
    output logic [INSTR_W-1:0] instr,
    output logic [XLEN-1:0]    instr_pc,
    input  logic               instr_ready,
    input  logic               redirect_valid,
    input  logic [XLEN-1:0]    redirect_pc
);

    localparam int CNT_W = $clog2(BUF_DEPTH) + 1;
    localparam logic [XLEN-1:0] ALIGN_MASK = ~XLEN'(3);

    fetch_state_t       r_state;
    logic [XLEN-1:0]    r_fetch_pc;
    logic [XLEN-1:0]    r_req_pc;
    logic [INSTR_W-1:0] r_last_instr;
    logic [XLEN-1:0]    r_last_pc;

    logic [CNT_W-1:0]   w_count;
    logic               w_full;
    logic               w_empty;
    fetch_entry_t       w_head;
    fetch_entry_t       w_push_entry;
    logic               w_keep;
    logic               w_pop;
    logic               w_issue;
    logic [CNT_W:0]     w_proj;

    // A redirect kills both the in-flight response and any pop this cycle.
    assign w_keep = (r_state == WAIT) && imem_rvalid && !redirect_valid;
    assign w_pop  = instr_valid && instr_ready && !redirect_valid;
    assign w_proj = (CNT_W+1)'(w_count) + (CNT_W+1)'(w_keep) - (CNT_W+1)'(w_pop);

    assign w_issue = rst_n && !redirect_valid
                  && ((r_state == IDLE) || ((r_state == WAIT) && imem_rvalid))
                  && (w_proj < (CNT_W+1)'(BUF_DEPTH));

    assign imem_req  = w_issue;
    assign imem_addr = w_issue ? r_fetch_pc : '0;

    assign w_push_entry.pc    = PC_W'(r_req_pc);
    assign w_push_entry.instr = imem_rdata;

    fetch_fifo #(.DEPTH(BUF_DEPTH)) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (w_keep),
        .pop   (w_pop),
        .flush (redirect_valid),
        .din   (w_push_entry),
        .count (w_count),
        .full  (w_full),
        .empty (w_empty),
        .head  (w_head)
    );

    // Outputs hold the last presented entry while the FIFO is empty.
    assign instr_valid = !w_empty;
    assign instr       = instr_valid ? w_head.instr : r_last_instr;
    assign instr_pc    = instr_valid ? XLEN'(w_head.pc) : r_last_pc;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_last_instr <= '0;
            r_last_pc    <= '0;
        end else if (instr_valid) begin
            r_last_instr <= w_head.instr;
            r_last_pc    <= XLEN'(w_head.pc);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= IDLE;
            r_fetch_pc <= RESET_PC & ALIGN_MASK;
            r_req_pc   <= '0;
        end else if (redirect_valid) begin
            r_fetch_pc <= redirect_pc & ALIGN_MASK;
            case (r_state)
                WAIT:    r_state <= imem_rvalid ? IDLE : DROP;
                // A response landing with the redirect still retires the drop.
                DROP:    r_state <= imem_rvalid ? IDLE : DROP;
                default: r_state <= IDLE;
            endcase
        end else if (w_issue) begin
            r_state    <= WAIT;
            r_req_pc   <= r_fetch_pc;
            r_fetch_pc <= r_fetch_pc + XLEN'(PC_STEP);
        end else if (imem_rvalid && (r_state != IDLE)) begin
            r_state <= IDLE;
        end
    end

    a_no_rvalid_idle: assert property (@(posedge clk) disable iff (!rst_n)
        !((r_state == IDLE) && imem_rvalid));

    a_space_reserved: assert property (@(posedge clk) disable iff (!rst_n)
        !(w_keep && w_full && !w_pop));

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed bench for instr_fetch_unit with a variable-latency imem model.
module tb_instr_fetch_unit;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        imem_req;
    logic [63:0] imem_addr;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic        instr_valid;
    logic [31:0] instr;
    logic [63:0] instr_pc;
    logic        instr_ready;
    logic        redirect_valid;
    logic [63:0] redirect_pc;

    instr_fetch_unit #(.XLEN(64), .RESET_PC(64'h100), .BUF_DEPTH(2)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .imem_req       (imem_req),
        .imem_addr      (imem_addr),
        .imem_rvalid    (imem_rvalid),
        .imem_rdata     (imem_rdata),
        .instr_valid    (instr_valid),
        .instr          (instr),
        .instr_pc       (instr_pc),
        .instr_ready    (instr_ready),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;
    int lat   = 1;
    logic        m_busy;
    int          m_cnt;
    logic [63:0] m_addr;
    logic        c_req, c_valid;
    logic [63:0] c_addr, c_pc;
    logic [31:0] c_instr;

    function automatic logic [31:0] mem_word(input logic [63:0] a);
        return a[31:0] ^ 32'h1357_9BDF;
    endfunction

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic mem_drive();
        imem_rvalid = 1'b0;
        if (!rst_n) begin
            m_busy = 1'b0;
        end else if (m_busy) begin
            m_cnt--;
            if (m_cnt == 0) begin
                imem_rvalid = 1'b1;
                imem_rdata  = mem_word(m_addr);
                m_busy      = 1'b0;
            end
        end
    endtask

    // Called at a negedge; returns at the next negedge with c_* holding
    // the values seen during the cycle.
    task automatic cycle();
        mem_drive();
        #1;
        c_req   = imem_req;
        c_addr  = imem_addr;
        c_valid = instr_valid;
        c_pc    = instr_pc;
        c_instr = instr;
        if (imem_req) begin
            m_busy = 1'b1;
            m_cnt  = lat;
            m_addr = imem_addr;
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst_n          = 1'b0;
        redirect_valid = 1'b0;
        imem_rvalid    = 1'b0;
        m_busy         = 1'b0;
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: bench did not finish");
        $fatal(1);
    end

    initial begin
        int n_req;
        int first_req_k, first_vld_k;
        logic [63:0] first_req_addr, first_vld_pc;
        logic        found, saw_stale, vld_k1;

        rst_n = 1'b0; instr_ready = 1'b1; redirect_valid = 1'b0; redirect_pc = '0;
        imem_rvalid = 1'b0; imem_rdata = '0; m_busy = 1'b0; m_cnt = 0; m_addr = '0;
        @(negedge clk);

        // Reset state
        cycle();
        chk("rst_req",   64'(c_req),   64'h0);
        chk("rst_addr",  c_addr,       64'h0);
        chk("rst_valid", 64'(c_valid), 64'h0);
        chk("rst_instr", 64'(c_instr), 64'h0);
        chk("rst_pc",    c_pc,         64'h0);

        // Streaming from RESET_PC with 1-cycle memory
        rst_n = 1'b1;
        for (int i = 0; i < 6; i++) begin
            cycle();
            chk($sformatf("t1_req%0d", i),  64'(c_req), 64'h1);
            chk($sformatf("t1_addr%0d", i), c_addr, 64'h100 + 64'(4 * i));
            chk($sformatf("t1_vld%0d", i),  64'(c_valid), 64'(i >= 2));
            if (i >= 2) begin
                chk($sformatf("t1_pc%0d", i),    c_pc, 64'h100 + 64'(4 * (i - 2)));
                chk($sformatf("t1_instr%0d", i), 64'(c_instr), 64'(mem_word(64'h100 + 64'(4 * (i - 2)))));
            end
        end

        // Back-pressure: buffer fills to depth, then drains in order
        instr_ready = 1'b0;
        do_reset();
        n_req = 0;
        for (int i = 0; i < 10; i++) begin
            cycle();
            n_req += int'(c_req);
        end
        chk("t2_nreq",  64'(n_req),   64'd2);
        chk("t2_valid", 64'(c_valid), 64'h1);
        chk("t2_hold",  c_pc,         64'h100);
        instr_ready = 1'b1;
        cycle();
        chk("t2_pc0",   c_pc,        64'h100);
        chk("t2_req",   64'(c_req),  64'h1);
        chk("t2_addr",  c_addr,      64'h108);
        cycle();
        chk("t2_pc1",   c_pc,        64'h104);
        cycle();
        chk("t2_pc2",   c_pc,        64'h108);
        chk("t2_ins2",  64'(c_instr), 64'(mem_word(64'h108)));

        // Redirect while a 3-cycle request is outstanding
        lat = 3;
        do_reset();
        found = 1'b0;
        for (int i = 0; i < 40 && !found; i++) begin
            cycle();
            if (c_req && c_addr == 64'h108) found = 1'b1;
        end
        chk("t3_saw108", 64'(found), 64'h1);
        redirect_valid = 1'b1; redirect_pc = 64'h2002;
        cycle();
        redirect_valid = 1'b0;
        chk("t3_noreq", 64'(c_req), 64'h0);
        first_req_k = -1; first_vld_k = -1; saw_stale = 1'b0; vld_k1 = 1'b1;
        first_req_addr = '0; first_vld_pc = '0;
        for (int k = 1; k <= 20; k++) begin
            cycle();
            if (k == 1) vld_k1 = c_valid;
            if (c_req && first_req_k < 0) begin first_req_k = k; first_req_addr = c_addr; end
            if (c_valid && first_vld_k < 0) begin first_vld_k = k; first_vld_pc = c_pc; end
            if (c_valid && c_pc == 64'h108) saw_stale = 1'b1;
        end
        chk("t3_vld_k1",  64'(vld_k1),      64'h0);
        chk("t3_reqk",    64'(first_req_k), 64'd3);
        chk("t3_reqaddr", first_req_addr,   64'h2000);
        chk("t3_vldpc",   first_vld_pc,     64'h2000);
        chk("t3_vldk",    64'(first_vld_k), 64'd7);
        chk("t3_stale",   64'(saw_stale),   64'h0);

        // Redirect coinciding with a kept response
        lat = 1;
        do_reset();
        repeat (3) cycle();
        redirect_valid = 1'b1; redirect_pc = 64'h3000;
        cycle();
        redirect_valid = 1'b0;
        chk("t4_noreq", 64'(c_req),   64'h0);
        chk("t4_popv",  64'(c_valid), 64'h1);
        cycle();
        chk("t4_empty", 64'(c_valid), 64'h0);
        chk("t4_req",   64'(c_req),   64'h1);
        chk("t4_addr",  c_addr,       64'h3000);
        cycle();
        chk("t4_empty2", 64'(c_valid), 64'h0);
        chk("t4_addr2",  c_addr,       64'h3004);
        cycle();
        chk("t4_pc",    c_pc,         64'h3000);
        chk("t4_vld",   64'(c_valid), 64'h1);

        // Asynchronous reset in the middle of streaming
        mem_drive();
        #1;
        chk("t5_pre_req", 64'(imem_req),    64'h1);
        chk("t5_pre_vld", 64'(instr_valid), 64'h1);
        rst_n = 1'b0;
        #1;
        chk("t5_req",   64'(imem_req),    64'h0);
        chk("t5_vld",   64'(instr_valid), 64'h0);
        chk("t5_addr",  imem_addr,        64'h0);
        chk("t5_pc",    instr_pc,         64'h0);
        m_busy = 1'b0; imem_rvalid = 1'b0;
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        cycle();
        chk("t5_restart", c_addr,      64'h100);
        chk("t5_rreq",    64'(c_req),  64'h1);

        // PC wrap at the top of the address space
        redirect_valid = 1'b1; redirect_pc = 64'hFFFF_FFFF_FFFF_FFFC;
        cycle();
        redirect_valid = 1'b0;
        cycle();
        chk("t6_addr_top", c_addr, 64'hFFFF_FFFF_FFFF_FFFC);
        cycle();
        chk("t6_addr_wrap", c_addr, 64'h0);
        chk("t6_wreq",      64'(c_req), 64'h1);
        cycle();
        chk("t6_pc_top",  c_pc, 64'hFFFF_FFFF_FFFF_FFFC);
        cycle();
        chk("t6_pc_wrap", c_pc, 64'h0);
        chk("t6_ins_wrap", 64'(c_instr), 64'(mem_word(64'h0)));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
